// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: iterative 32x32 multiply / 32/32 divide for the EXE stage.
// One shift-add or restoring-divide step per cycle over 32 cycles, then a sign
// fix-up cycle, then a result write.
//
// Output timing: the result is written into Hi/Lo at the edge that leaves the
// DONE state. Done is registered on that same edge, so the Done pulse and the
// new Hi/Lo values appear together in the following cycle. Busy remains high
// through that Done cycle. Counting from the Start edge, Done is therefore
// visible after 35 edges.
module exe_muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] SregData,
    input  logic [31:0] TregData,
    input  logic        Flush,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        DivByZero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic        r_done;

    // Latched operation context
    logic        r_is_div;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [31:0] r_mag_a;
    logic [31:0] r_mag_b;
    logic [31:0] r_raw_a;
    // Multiply: {partial high, multiplier/product low}; divide: {remainder, quotient}
    logic [63:0] r_acc;

    logic        w_accept;
    logic        w_signed_op;
    logic        w_sa;
    logic        w_sb;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_trial;
    logic [63:0] w_div_next;
    logic [63:0] w_fix_next;
    logic        w_div_zero;

    // Two's complement negate when requested
    function automatic logic [31:0] f_cneg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] f_cneg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    assign w_signed_op = ~Op[0];
    assign w_sa        = w_signed_op & SregData[31];
    assign w_sb        = w_signed_op & TregData[31];
    assign w_div_zero  = (r_mag_b == 32'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; Flush overrides everything
    always_comb begin
        w_next = r_state;
        if (Flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (Start && !r_done) w_next = S_RUN;
                S_RUN:   if (r_cnt == 5'd0)    w_next = S_FIX;
                S_FIX:   w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Control outputs; the Done cycle still counts as busy
    always_comb begin
        Busy     = (r_state != S_IDLE) || r_done;
        w_accept = (r_state == S_IDLE) && !r_done && Start && !Flush;
    end

    // Iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 5'd0;
        end else if (w_accept) begin
            r_cnt <= 5'd31;
        end else if (r_state == S_RUN && r_cnt != 5'd0) begin
            r_cnt <= r_cnt - 5'd1;
        end
    end

    // One multiply or divide step plus the sign correction
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);
        w_mul_next  = {w_mul_sum, r_acc[31:1]};
        w_div_trial = r_acc[63:31] - {1'b0, r_mag_b};
        if (!w_div_trial[32]) begin
            w_div_next = {w_div_trial[31:0], r_acc[30:0], 1'b1};
        end else begin
            w_div_next = {r_acc[62:0], 1'b0};
        end
        if (!r_is_div) begin
            w_fix_next = f_cneg64(r_acc, r_sign_a ^ r_sign_b);
        end else if (w_div_zero) begin
            w_fix_next = {r_raw_a, 32'hFFFF_FFFF};
        end else begin
            w_fix_next = {f_cneg32(r_acc[63:32], r_sign_a),
                          f_cneg32(r_acc[31:0], r_sign_a ^ r_sign_b)};
        end
    end

    // Operand capture and working accumulator (datapath, no reset needed)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_div <= Op[1];
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_mag_a  <= f_cneg32(SregData, w_sa);
            r_mag_b  <= f_cneg32(TregData, w_sb);
            r_raw_a  <= SregData;
            r_acc    <= Op[1] ? {32'd0, f_cneg32(SregData, w_sa)}
                              : {32'd0, f_cneg32(TregData, w_sb)};
        end else if (r_state == S_RUN) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
        end else if (r_state == S_FIX) begin
            r_acc <= w_fix_next;
        end
    end

    // Architectural result registers and the Done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Hi        <= 32'd0;
            Lo        <= 32'd0;
            DivByZero <= 1'b0;
            r_done    <= 1'b0;
        end else if (r_state == S_DONE && !Flush) begin
            Hi        <= r_acc[63:32];
            Lo        <= r_acc[31:0];
            DivByZero <= r_is_div && w_div_zero;
            r_done    <= 1'b1;
        end else begin
            r_done    <= 1'b0;
        end
    end

    assign Done = r_done;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// tb_exe_muldiv_unit: directed and randomized checks of exe_muldiv_unit
// against a transaction-level reference model.
module tb_exe_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        fl;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;

    int n_cmp;
    int n_err;

    // Reference model state: cycles left in the busy window (35 = just accepted)
    int          m_left;
    logic [31:0] p_hi, p_lo, e_hi, e_lo;
    logic        p_dbz, e_dbz;

    exe_muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (start),
        .Op        (op),
        .SregData  (a),
        .TregData  (b),
        .Flush     (fl),
        .Busy      (busy),
        .Done      (done),
        .Hi        (hi),
        .Lo        (lo),
        .DivByZero (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Architectural result from plain arithmetic
    function automatic void model_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] prod;
        logic [63:0] tq, tr;
        p_dbz = 1'b0;
        case (o)
            2'b00: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                prod = 64'(sx * sy);
                {p_hi, p_lo} = prod;
            end
            2'b01: begin
                prod = {32'd0, x} * {32'd0, y};
                {p_hi, p_lo} = prod;
            end
            default: begin
                if (y == 32'd0) begin
                    p_lo  = 32'hFFFF_FFFF;
                    p_hi  = x;
                    p_dbz = 1'b1;
                end else if (o == 2'b10) begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    q  = sx / sy;
                    r  = sx % sy;
                    tq = 64'(q);
                    tr = 64'(r);
                    p_lo = tq[31:0];
                    p_hi = tr[31:0];
                end else begin
                    p_lo = x / y;
                    p_hi = x % y;
                end
            end
        endcase
    endfunction

    // One clock: advance the model with the inputs the DUT sampled, then check
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_left = 0;
            e_hi = 32'd0; e_lo = 32'd0; e_dbz = 1'b0;
        end else if (m_left == 0) begin
            if (start && !fl) begin
                model_calc(op, a, b);
                m_left = 35;
            end
        end else if (fl && m_left > 1) begin
            m_left = 0;
        end else begin
            m_left--;
            if (m_left == 1) begin
                e_hi = p_hi; e_lo = p_lo; e_dbz = p_dbz;
            end
        end
        #1;
        chk("busy", 64'(busy), 64'(m_left > 0));
        chk("done", 64'(done), 64'(m_left == 1));
        chk("hi",   64'(hi),   64'(e_hi));
        chk("lo",   64'(lo),   64'(e_lo));
        chk("dbz",  64'(dbz),  64'(e_dbz));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && m_left != 0; k++) tick();
    endtask

    task automatic pulse_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        pulse_start(o, x, y);
        wait_idle();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_cmp = 0; n_err = 0; m_left = 0;
        e_hi = 0; e_lo = 0; e_dbz = 0; p_hi = 0; p_lo = 0; p_dbz = 0;
        start = 0; op = 0; a = 0; b = 0; fl = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_dbz",  64'(dbz), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;

        // Signed multiply, first Start right after reset release
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("div_dbz", 64'(dbz), 64'd0);
        run_op(2'b11, 32'd5, 32'd0);
        chk("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("divu0_hi", 64'(hi), 64'd5);
        chk("divu0_dbz", 64'(dbz), 64'd1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_lo", 64'(lo), 64'h8000_0000);
        chk("divovf_hi", 64'(hi), 64'd0);
        chk("divovf_dbz", 64'(dbz), 64'd0);
        run_op(2'b10, 32'h8000_0000, 32'd0);
        chk("div0_hi", 64'(hi), 64'h8000_0000);
        run_op(2'b00, 32'd2, 32'd3);
        chk("mul_clr_dbz", 64'(dbz), 64'd0);

        // Starts while busy are ignored
        pulse_start(2'b01, 32'd3, 32'd5);
        for (int c = 1; c < 40; c++) begin
            start = (c == 3 || c == 20);
            op = 2'b01; a = 32'd9; b = 32'd9;
            tick();
        end
        start = 1'b0;
        wait_idle();
        chk("ignore_lo", 64'(lo), 64'd15);
        chk("ignore_hi", 64'(hi), 64'd0);

        // Flush mid-divide, then a fresh Start two cycles later
        pulse_start(2'b11, 32'd1000, 32'd7);
        repeat (9) tick();
        fl = 1'b1;
        tick();
        fl = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        tick();
        run_op(2'b11, 32'd1000, 32'd7);
        chk("after_flush_lo", 64'(lo), 64'd142);
        chk("after_flush_hi", 64'(hi), 64'd6);

        // Flush wins over Start in the same cycle
        start = 1'b1; fl = 1'b1; op = 2'b00; a = 32'd4; b = 32'd4;
        tick();
        start = 1'b0; fl = 1'b0;
        chk("flush_prio", 64'(busy), 64'd0);
        repeat (2) tick();

        // Asynchronous reset in the middle of an operation
        pulse_start(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) tick();
        rst_n = 1'b0;
        #2;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        chk("arst_dbz", 64'(dbz), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);

        // Randomized operations with stray Starts and occasional Flush
        for (int n = 0; n < 60; n++) begin
            int flush_at;
            flush_at = (($urandom % 6) == 0) ? int'($urandom_range(1, 36)) : -1;
            pulse_start(2'($urandom), pick(), pick());
            for (int k = 1; k < 100 && m_left != 0; k++) begin
                start = (($urandom % 8) == 0);
                op = 2'($urandom); a = $urandom; b = $urandom;
                fl = (k == flush_at);
                tick();
            end
            start = 1'b0; fl = 1'b0;
            repeat ($urandom % 3) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
